// File: rtl/seq_gen_drv.sv
// seq_gen_drv: drives one command into a sequence-generator DUT and returns its result.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid may not drop before that edge, and the payload is stable while valid is 1.
// Flow: IDLE -> LOAD1 -> LOAD2 -> WAIT -> RESP -> CLEAR -> IDLE. Every output is a flop
// loaded from the next-state decode, so outputs track the state they belong to.
module seq_gen_drv #(
  parameter int unsigned TIMEOUT_SLACK = 2,
  parameter int unsigned CLEAR_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [15:0] cmd_order,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [63:0] rsp_data,
  output logic [16:0] rsp_cycles,
  output logic        spurious,
  output logic        load,
  output logic        clear,
  output logic        fibonacci,
  output logic        triangle,
  output logic [15:0] order,
  output logic [63:0] data_in,
  input  logic        done,
  input  logic        overflow,
  input  logic        error,
  input  logic [63:0] data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD1 = 3'd1;
  localparam logic [2:0] S_LOAD2 = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_OVERFLOW = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [16:0] cnt_q, cnt_d;        // WAIT cycle counter, reused to time CLEAR
  logic        cap_mode_q, cap_mode_d;
  logic [15:0] cap_order_q, cap_order_d;
  logic [63:0] cap_data_q, cap_data_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [16:0] rsp_cycles_q, rsp_cycles_d;
  logic        spurious_q, spurious_d;
  logic        load_q, load_d;
  logic        clear_q, clear_d;
  logic        fibonacci_q, fibonacci_d;
  logic        triangle_q, triangle_d;
  logic [15:0] order_q, order_d;
  logic [63:0] data_in_q, data_in_d;

  // Timeout bound is computed in 17 bits so order=0xFFFF does not wrap.
  logic [16:0] limit;
  logic [16:0] cnt_inc;
  assign limit   = {1'b0, cap_order_q} + 17'(TIMEOUT_SLACK);
  assign cnt_inc = cnt_q + 17'd1;

  // Next-state, capture and response decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_mode_d   = cap_mode_q;
    cap_order_d  = cap_order_q;
    cap_data_d   = cap_data_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    rsp_cycles_d = rsp_cycles_q;
    spurious_d   = spurious_q | ((done | overflow | error) & (state_q != S_WAIT));
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cap_mode_d  = cmd_mode;
          cap_order_d = cmd_order;
          cap_data_d  = cmd_data;
          state_d     = S_LOAD1;
        end
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: begin
        state_d = S_WAIT;
        cnt_d   = 17'd0;
      end
      S_WAIT: begin
        if (error) begin
          rsp_status_d = ST_ERROR;
          rsp_data_d   = 64'd0;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end else if (overflow) begin
          rsp_status_d = ST_OVERFLOW;
          rsp_data_d   = data_out;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end else if (done) begin
          rsp_status_d = ST_OK;
          rsp_data_d   = data_out;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end else if (cnt_inc == limit) begin
          rsp_status_d = ST_TIMEOUT;
          rsp_data_d   = 64'd0;
          rsp_cycles_d = limit;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_CLEAR;
          cnt_d   = 17'd0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == 17'(CLEAR_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = 17'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 17'd0;
      end
    endcase
  end

  // Output decode from the next state so each registered output lines up with its state.
  always_comb begin
    load_d      = (state_d == S_LOAD1) || (state_d == S_LOAD2);
    fibonacci_d = load_d & ~cap_mode_d;
    triangle_d  = load_d & cap_mode_d;
    order_d     = load_d ? cap_order_d : 16'd0;
    data_in_d   = load_d ? cap_data_d : 64'd0;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    clear_d     = (state_d == S_CLEAR);
  end

  // State, capture and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 17'd0;
      cap_mode_q   <= 1'b0;
      cap_order_q  <= 16'd0;
      cap_data_q   <= 64'd0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_data_q   <= 64'd0;
      rsp_cycles_q <= 17'd0;
      spurious_q   <= 1'b0;
      load_q       <= 1'b0;
      clear_q      <= 1'b0;
      fibonacci_q  <= 1'b0;
      triangle_q   <= 1'b0;
      order_q      <= 16'd0;
      data_in_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_mode_q   <= cap_mode_d;
      cap_order_q  <= cap_order_d;
      cap_data_q   <= cap_data_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cycles_q <= rsp_cycles_d;
      spurious_q   <= spurious_d;
      load_q       <= load_d;
      clear_q      <= clear_d;
      fibonacci_q  <= fibonacci_d;
      triangle_q   <= triangle_d;
      order_q      <= order_d;
      data_in_q    <= data_in_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cycles = rsp_cycles_q;
  assign spurious   = spurious_q;
  assign load       = load_q;
  assign clear      = clear_q;
  assign fibonacci  = fibonacci_q;
  assign triangle   = triangle_q;
  assign order      = order_q;
  assign data_in    = data_in_q;

endmodule

// File: tb/tb_seq_gen_drv.sv
// Bench for seq_gen_drv: the bench plays the sequence-generator DUT, injects status events
// at chosen WAIT cycles and compares each response with a transaction-level model.
module tb_seq_gen_drv;

  localparam int SLACK = 2;
  localparam int CLR   = 1;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [15:0] cmd_order;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [63:0] rsp_data;
  logic [16:0] rsp_cycles;
  logic        spurious;
  logic        load;
  logic        clear;
  logic        fibonacci;
  logic        triangle;
  logic [15:0] order;
  logic [63:0] data_in;
  logic        done;
  logic        overflow;
  logic        error;
  logic [63:0] data_out;

  int n_checks;
  int n_errors;

  seq_gen_drv #(.TIMEOUT_SLACK(SLACK), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_order(cmd_order), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_data(rsp_data), .rsp_cycles(rsp_cycles), .spurious(spurious),
    .load(load), .clear(clear), .fibonacci(fibonacci), .triangle(triangle),
    .order(order), .data_in(data_in),
    .done(done), .overflow(overflow), .error(error), .data_out(data_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which WAIT cycle ends the command and with what response.
  // kind = {error, overflow, done} driven for one cycle at WAIT cycle ev_cyc (0 = silent).
  function automatic void model(input int ord, input int ev_cyc, input logic [2:0] kind,
                                input logic [63:0] dout, output int term,
                                output logic [1:0] st, output logic [63:0] dat);
    int limit;
    limit = ord + SLACK;
    if (kind != 3'b000 && ev_cyc >= 1 && ev_cyc <= limit) begin
      term = ev_cyc;
      if (kind[2]) begin
        st = 2'b10; dat = 64'd0;
      end else if (kind[1]) begin
        st = 2'b01; dat = dout;
      end else begin
        st = 2'b00; dat = dout;
      end
    end else begin
      term = limit;
      st   = 2'b11;
      dat  = 64'd0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_val("rst.ready_low_before_edge", cmd_ready, 1'b0);
    step();
    chk_val("rst.ready_after_release", cmd_ready, 1'b1);
  endtask

  // Driver: one full command through to the end of CLEAR.
  task automatic run_cmd(input string tag, input logic mode, input logic [15:0] ord,
                         input logic [63:0] din, input int ev_cyc, input logic [2:0] kind,
                         input logic [63:0] dout, input int hold);
    int          term;
    logic [1:0]  st;
    logic [63:0] dat;
    int          guard;
    model(int'(ord), ev_cyc, kind, dout, term, st, dat);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    chk_val({tag, ".cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_order = ord; cmd_data = din;
    step();
    // LOAD1: keep garbage on the command port, it must be ignored
    cmd_mode = ~mode; cmd_order = 16'($urandom); cmd_data = {$urandom, $urandom};
    chk_val({tag, ".l1_load"}, load, 1'b1);
    chk_val({tag, ".l1_ready"}, cmd_ready, 1'b0);
    chk_val({tag, ".l1_fib"}, fibonacci, !mode);
    chk_val({tag, ".l1_tri"}, triangle, mode);
    chk_val({tag, ".l1_order"}, order, ord);
    chk_val({tag, ".l1_data"}, data_in, din);
    step();
    chk_val({tag, ".l2_load"}, load, 1'b1);
    chk_val({tag, ".l2_fib"}, fibonacci, !mode);
    chk_val({tag, ".l2_tri"}, triangle, mode);
    chk_val({tag, ".l2_order"}, order, ord);
    chk_val({tag, ".l2_data"}, data_in, din);
    step();
    cmd_valid = 1'b0;
    chk_val({tag, ".w_load"}, load, 1'b0);
    chk_val({tag, ".w_fibtri"}, {fibonacci, triangle}, 2'b00);
    chk_val({tag, ".w_order"}, order, 16'd0);
    chk_val({tag, ".w_data"}, data_in, 64'd0);
    for (int k = 1; k <= term; k++) begin
      if (k == ev_cyc) begin
        {error, overflow, done} = kind;
        data_out = dout;
      end
      chk_val({tag, ".wait_no_rsp"}, rsp_valid, 1'b0);
      step();
      {error, overflow, done} = 3'b000;
      data_out = {$urandom, $urandom};
    end
    chk_val({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk_val({tag, ".rsp_status"}, rsp_status, st);
    chk_val({tag, ".rsp_data"}, rsp_data, dat);
    chk_val({tag, ".rsp_cycles"}, rsp_cycles, 64'(term));
    chk_val({tag, ".rsp_ready_out"}, cmd_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk_val({tag, ".hold_valid"}, rsp_valid, 1'b1);
      chk_val({tag, ".hold_status"}, rsp_status, st);
      chk_val({tag, ".hold_data"}, rsp_data, dat);
      chk_val({tag, ".hold_cycles"}, rsp_cycles, 64'(term));
      chk_val({tag, ".hold_cmd_ready"}, cmd_ready, 1'b0);
      chk_val({tag, ".hold_clear"}, clear, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk_val({tag, ".clr_valid"}, rsp_valid, 1'b0);
    chk_val({tag, ".clr_clear"}, clear, 1'b1);
    chk_val({tag, ".clr_cmd_ready"}, cmd_ready, 1'b0);
    for (int c = 1; c < CLR; c++) begin
      step();
      chk_val({tag, ".clr_hold"}, clear, 1'b1);
    end
    step();
    chk_val({tag, ".post_clear"}, clear, 1'b0);
    chk_val({tag, ".post_ready"}, cmd_ready, 1'b1);
  endtask

  // Scenario sequence and final report.
  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_order = 16'd0; cmd_data = 64'd0;
    rsp_ready = 1'b0; done = 1'b0; overflow = 1'b0; error = 1'b0; data_out = 64'd0;
    #2;
    chk_val("reset.cmd_ready", cmd_ready, 1'b0);
    chk_val("reset.rsp_valid", rsp_valid, 1'b0);
    chk_val("reset.load", load, 1'b0);
    chk_val("reset.clear", clear, 1'b0);
    chk_val("reset.spurious", spurious, 1'b0);
    chk_val("reset.order", order, 16'd0);
    chk_val("reset.data_in", data_in, 64'd0);
    chk_val("reset.rsp_data", rsp_data, 64'd0);
    do_reset();

    run_cmd("fib", 1'b0, 16'd10, 64'd1, 5, 3'b001, 64'd89, 0);
    run_cmd("tri_timeout", 1'b1, 16'd3, 64'd7, 0, 3'b000, 64'd0, 0);
    run_cmd("err_done", 1'b0, 16'd8, 64'd2, 2, 3'b101, 64'h1234, 1);
    run_cmd("ovf_hold", 1'b0, 16'd6, 64'd3, 3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    run_cmd("order0_to", 1'b1, 16'd0, 64'd5, 0, 3'b000, 64'd0, 0);
    run_cmd("ev_at_limit", 1'b1, 16'd4, 64'd9, 6, 3'b001, 64'hABCD, 0);
    run_cmd("ev_past_limit", 1'b0, 16'd4, 64'd9, 7, 3'b001, 64'hABCD, 0);
    run_cmd("ev_first", 1'b0, 16'd2, 64'd4, 1, 3'b011, 64'h55, 2);

    // Reset in the middle of LOAD
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_order = 16'd5; cmd_data = 64'd11;
    step();
    cmd_valid = 1'b0;
    chk_val("rst_load.load_before", load, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_val("rst_load.load", load, 1'b0);
    chk_val("rst_load.order", order, 16'd0);
    do_reset();

    // Reset in the 2nd WAIT cycle
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_order = 16'd6; cmd_data = 64'd12;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk_val("rst_wait.load", load, 1'b0);
    chk_val("rst_wait.clear", clear, 1'b0);
    chk_val("rst_wait.rsp_valid", rsp_valid, 1'b0);
    chk_val("rst_wait.cmd_ready", cmd_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk_val("rst_wait.no_rsp", rsp_valid, 1'b0);
      step();
    end

    // Spurious done in IDLE
    chk_val("spur.before", spurious, 1'b0);
    done = 1'b1; data_out = 64'h77;
    step();
    done = 1'b0;
    chk_val("spur.set", spurious, 1'b1);
    chk_val("spur.fsm_idle", cmd_ready, 1'b1);
    chk_val("spur.no_rsp", rsp_valid, 1'b0);
    run_cmd("after_spur", 1'b0, 16'd5, 64'd13, 4, 3'b001, 64'h99, 0);
    chk_val("spur.sticky", spurious, 1'b1);

    // Randomized commands
    for (int n = 0; n < 25; n++) begin
      logic [15:0] ord;
      logic [2:0]  kind;
      ord  = 16'($urandom_range(0, 12));
      kind = 3'($urandom_range(0, 7));
      run_cmd("rand", 1'($urandom), ord, {$urandom, $urandom},
              int'($urandom_range(0, int'(ord) + 4)), kind,
              {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end
    chk_val("spur.end", spurious, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
